// File: rtl/wb_ssram_ctrl_if.sv
// wb_ssram_ctrl_if: Wishbone classic bus between system master and the SSRAM controller
interface wb_ssram_ctrl_if;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  modport slave (
    input  wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_data_o, wb_ack_o, wb_err_o
  );
  modport master (
    output wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_data_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_ssram_ctrl.sv
// wb_ssram_ctrl: Wishbone slave driving up to eight banks of pipelined synchronous SSRAM
module wb_ssram_ctrl #(
  parameter int          RD_LAT   = 2,
  parameter logic [31:0] POC_INIT = 32'h0000_0002
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_ssram_ctrl_if.slave wb,
  input  logic        susp_req_i,
  input  logic        resume_req_i,
  output logic        suspended_o,
  output logic [31:0] poc_o,
  output logic [23:0] mc_addr_o,
  output logic [31:0] mc_data_o,
  input  logic [31:0] mc_data_i,
  output logic        mc_doe_o,
  output logic [3:0]  mc_dqm_o,
  output logic [7:0]  mc_cs_o_,
  output logic        mc_adsc_o_,
  output logic        mc_adv_o_,
  output logic        mc_we_o_,
  output logic        mc_oe_o_,
  output logic        mc_zz_o
);
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_OE, ACK, ERR, SUSP} state_t;
  state_t st, nxt;
  logic [7:0] csc;
  logic [1:0] cnt;
  logic req, is_reg, is_mem, err_req, csc_hit, ld, mem_d, unused_addr;
  logic [2:0] bank, n;
  logic [21:0] w;
  logic [31:0] reg_rd;
  logic ack_d, err_d, adsc_d, we_d, oe_d, doe_d, sus_d;
  logic [7:0] cs_d;
  logic [3:0] dqm_d;
  logic [23:0] addr_d;
  logic [31:0] data_d, rdat_d;
  assign req         = wb.wb_cyc_i & wb.wb_stb_i;
  assign is_reg      = wb.wb_addr_i[31:24] == 8'h60;
  assign is_mem      = wb.wb_addr_i[31:26] == 6'd0;
  assign bank        = wb.wb_addr_i[25:23];
  assign err_req     = !is_reg && !(is_mem && csc[bank]);
  assign w           = wb.wb_addr_i[23:2];
  assign csc_hit     = w >= 22'd4 && w <= 22'd11;
  assign n           = w[2:0] - 3'd4;
  assign reg_rd      = w == 22'd0 ? {31'b0, suspended_o} : w == 22'd1 ? POC_INIT : csc_hit ? {31'b0, csc[n]} : 32'b0;
  assign ld          = nxt == ACK && (st == IDLE || st == SUSP);
  assign unused_addr = ^wb.wb_addr_i[1:0];
  assign mc_adv_o_   = 1'b1;
  assign poc_o       = POC_INIT;
  // state register
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) st <= IDLE;
    else st <= nxt;
  // next state: suspend beats any request in IDLE, resume beats any request in SUSP
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = susp_req_i ? SUSP : !req ? IDLE : err_req ? ERR : is_reg ? ACK : wb.wb_we_i ? WR : RD_ADDR;
      WR:      nxt = ACK;
      RD_ADDR: nxt = RD_OE;
      RD_OE:   nxt = cnt == 2'd0 ? ACK : RD_OE;
      ACK:     nxt = suspended_o ? SUSP : IDLE;
      ERR:     nxt = suspended_o ? SUSP : IDLE;
      SUSP:    nxt = resume_req_i ? IDLE : !req ? SUSP : is_reg ? ACK : ERR;
      default: nxt = IDLE;
    endcase
  end
  // output values for the state being entered, so every pad and bus output comes straight from a flop
  always_comb begin
    mem_d  = nxt == WR || nxt == RD_ADDR;
    ack_d  = nxt == ACK;
    err_d  = nxt == ERR;
    cs_d   = mem_d ? ~(8'd1 << bank) : 8'hFF;
    adsc_d = !mem_d;
    we_d   = nxt != WR;
    oe_d   = nxt != RD_OE;
    doe_d  = nxt == WR;
    dqm_d  = nxt == WR ? ~wb.wb_sel_i : nxt == RD_OE ? 4'h0 : 4'hF;
    addr_d = mem_d ? {3'b0, wb.wb_addr_i[22:2]} : mc_addr_o;
    data_d = nxt == WR ? wb.wb_data_i : mc_data_o;
    rdat_d = st == RD_OE && cnt == 2'd0 ? mc_data_i : ld && !wb.wb_we_i ? reg_rd : wb.wb_data_o;
    sus_d  = st == SUSP && resume_req_i ? 1'b0 : nxt == SUSP ? 1'b1 : suspended_o;
  end
  // registered outputs
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_err_o <= 1'b0;
      wb.wb_data_o <= 32'b0;
      mc_cs_o_ <= 8'hFF;
      mc_adsc_o_ <= 1'b1;
      mc_we_o_ <= 1'b1;
      mc_oe_o_ <= 1'b1;
      mc_doe_o <= 1'b0;
      mc_dqm_o <= 4'hF;
      mc_addr_o <= 24'b0;
      mc_data_o <= 32'b0;
      suspended_o <= 1'b0;
      mc_zz_o <= 1'b0;
    end else begin
      wb.wb_ack_o <= ack_d;
      wb.wb_err_o <= err_d;
      wb.wb_data_o <= rdat_d;
      mc_cs_o_ <= cs_d;
      mc_adsc_o_ <= adsc_d;
      mc_we_o_ <= we_d;
      mc_oe_o_ <= oe_d;
      mc_doe_o <= doe_d;
      mc_dqm_o <= dqm_d;
      mc_addr_o <= addr_d;
      mc_data_o <= data_d;
      suspended_o <= sus_d;
      mc_zz_o <= sus_d;
    end
  // bank enables and the read-latency countdown, reloaded in RD_ADDR before each use
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      csc <= 8'h01;
      cnt <= 2'd0;
    end else begin
      cnt <= st == RD_ADDR ? 2'(RD_LAT - 1) : cnt - 2'd1;
      if (ld && wb.wb_we_i && csc_hit && wb.wb_sel_i[0]) csc[n] <= wb.wb_data_i[0];
    end
endmodule

// File: tb/tb_wb_ssram_ctrl.sv
// tb_wb_ssram_ctrl: directed vector table plus suspend and mid-read reset sequences
module tb_wb_ssram_ctrl;
  logic clk_i = 1'b0, rst_i = 1'b0, susp_req_i = 1'b0, resume_req_i = 1'b0;
  logic suspended_o, mc_doe_o, mc_adsc_o_, mc_adv_o_, mc_we_o_, mc_oe_o_, mc_zz_o;
  logic [31:0] poc_o, mc_data_o, mc_data_i, mdl = 32'h0;
  logic [23:0] mc_addr_o;
  logic [3:0] mc_dqm_o;
  logic [7:0] mc_cs_o_;
  int checks = 0, fails = 0;
  localparam logic [20:0] CTL_RST = {8'hFF, 4'b1111, 1'b0, 4'hF, 4'b0000};
  wb_ssram_ctrl_if wb ();
  wb_ssram_ctrl #(.RD_LAT(2), .POC_INIT(32'h0000_0002)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb(wb.slave),
    .susp_req_i(susp_req_i), .resume_req_i(resume_req_i), .suspended_o(suspended_o), .poc_o(poc_o),
    .mc_addr_o(mc_addr_o), .mc_data_o(mc_data_o), .mc_data_i(mc_data_i), .mc_doe_o(mc_doe_o),
    .mc_dqm_o(mc_dqm_o), .mc_cs_o_(mc_cs_o_), .mc_adsc_o_(mc_adsc_o_), .mc_adv_o_(mc_adv_o_),
    .mc_we_o_(mc_we_o_), .mc_oe_o_(mc_oe_o_), .mc_zz_o(mc_zz_o)
  );
  always #5 clk_i = ~clk_i;
  assign mc_data_i = mc_oe_o_ ? 32'h0 : mdl;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] mdat;
    logic        err;
    int          lat;
    logic [31:0] rdat;
    logic        chk_rd;
    logic        mem;
    logic [7:0]  cs;
    logic [23:0] maddr;
    int          oe;
  } vec_t;
  vec_t tv[17];
  function automatic logic [20:0] ctl();
    return {mc_cs_o_, mc_adsc_o_, mc_adv_o_, mc_we_o_, mc_oe_o_, mc_doe_o, mc_dqm_o, mc_zz_o, suspended_o, wb.wb_ack_o, wb.wb_err_o};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic run(input vec_t v, input string nm);
    int lat = 0, oe_cnt = 0;
    logic gerr = 1'b0;
    logic [7:0] cs_and = 8'hFF;
    logic [23:0] s_addr = '0;
    logic [3:0] s_dqm = '0;
    logic s_doe = 1'b0;
    logic [31:0] s_data = '0;
    @(negedge clk_i);
    wb.wb_we_i = v.we; wb.wb_addr_i = v.addr; wb.wb_data_i = v.wdat; wb.wb_sel_i = v.sel; mdl = v.mdat;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk_i); #1;
      cs_and &= mc_cs_o_;
      if (!mc_oe_o_) oe_cnt++;
      if (!mc_adsc_o_) begin s_addr = mc_addr_o; s_dqm = mc_dqm_o; s_doe = mc_doe_o; s_data = mc_data_o; end
      if (wb.wb_ack_o || wb.wb_err_o) begin lat = i; gerr = wb.wb_err_o; end
    end
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    chk({nm, "_lat"}, lat, v.lat);
    chk({nm, "_err"}, {31'b0, gerr}, {31'b0, v.err});
    chk({nm, "_cs"}, {24'b0, cs_and}, {24'b0, v.cs});
    chk({nm, "_oe"}, oe_cnt, v.oe);
    if (v.chk_rd) chk({nm, "_rdat"}, wb.wb_data_o, v.rdat);
    if (v.mem && !v.err) chk({nm, "_maddr"}, {8'b0, s_addr}, {8'b0, v.maddr});
    if (v.mem && !v.err && v.we) begin
      chk({nm, "_dqm"}, {28'b0, s_dqm}, {28'b0, ~v.sel});
      chk({nm, "_doe"}, {31'b0, s_doe}, 32'h1);
      chk({nm, "_wdat"}, s_data, v.wdat);
    end
    @(posedge clk_i); #1;
    chk({nm, "_pulse"}, {30'b0, wb.wb_ack_o, wb.wb_err_o}, 32'h0);
  endtask
  initial begin
    vec_t rv;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_addr_i = '0; wb.wb_data_i = '0; wb.wb_sel_i = 4'hF;
    tv[0]  = '{1'b1, 32'h6000_001C, 32'h1,         4'hF,    32'h0,         1'b0, 1, 32'h0,         1'b0, 1'b0, 8'hFF, 24'h0,      0};
    tv[1]  = '{1'b0, 32'h6000_001C, 32'h0,         4'hF,    32'h0,         1'b0, 1, 32'h1,         1'b1, 1'b0, 8'hFF, 24'h0,      0};
    tv[2]  = '{1'b0, 32'h6000_0010, 32'h0,         4'hF,    32'h0,         1'b0, 1, 32'h1,         1'b1, 1'b0, 8'hFF, 24'h0,      0};
    tv[3]  = '{1'b0, 32'h6000_0004, 32'h0,         4'hF,    32'h0,         1'b0, 1, 32'h2,         1'b1, 1'b0, 8'hFF, 24'h0,      0};
    tv[4]  = '{1'b0, 32'h6000_0000, 32'h0,         4'hF,    32'h0,         1'b0, 1, 32'h0,         1'b1, 1'b0, 8'hFF, 24'h0,      0};
    tv[5]  = '{1'b0, 32'h6000_0008, 32'h0,         4'hF,    32'h0,         1'b0, 1, 32'h0,         1'b1, 1'b0, 8'hFF, 24'h0,      0};
    tv[6]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF,  4'b0011, 32'h0,         1'b0, 2, 32'h0,         1'b0, 1'b1, 8'hFE, 24'h4,      0};
    tv[7]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF,    32'hCAFEF00D,  1'b0, 4, 32'hCAFEF00D,  1'b1, 1'b1, 8'hFE, 24'h4,      2};
    tv[8]  = '{1'b0, 32'h0080_0000, 32'h0,         4'hF,    32'h0,         1'b1, 1, 32'h0,         1'b0, 1'b1, 8'hFF, 24'h0,      0};
    tv[9]  = '{1'b0, 32'h4000_0000, 32'h0,         4'hF,    32'h0,         1'b1, 1, 32'h0,         1'b0, 1'b0, 8'hFF, 24'h0,      0};
    tv[10] = '{1'b0, 32'h0180_0004, 32'h0,         4'hF,    32'h12345678,  1'b0, 4, 32'h12345678,  1'b1, 1'b1, 8'hF7, 24'h1,      2};
    tv[11] = '{1'b1, 32'h6000_0010, 32'h0,         4'hF,    32'h0,         1'b0, 1, 32'h0,         1'b0, 1'b0, 8'hFF, 24'h0,      0};
    tv[12] = '{1'b1, 32'h0000_0020, 32'h11111111,  4'hF,    32'h0,         1'b1, 1, 32'h0,         1'b0, 1'b1, 8'hFF, 24'h0,      0};
    tv[13] = '{1'b1, 32'h6000_0010, 32'h1,         4'hF,    32'h0,         1'b0, 1, 32'h0,         1'b0, 1'b0, 8'hFF, 24'h0,      0};
    tv[14] = '{1'b1, 32'h6000_000C, 32'hFFFFFFFF,  4'hF,    32'h0,         1'b0, 1, 32'h0,         1'b0, 1'b0, 8'hFF, 24'h0,      0};
    tv[15] = '{1'b0, 32'h6000_000C, 32'h0,         4'hF,    32'h0,         1'b0, 1, 32'h0,         1'b1, 1'b0, 8'hFF, 24'h0,      0};
    tv[16] = '{1'b1, 32'h0040_0008, 32'hA5A5A5A5,  4'b1000, 32'h0,         1'b0, 2, 32'h0,         1'b0, 1'b1, 8'hFE, 24'h100002, 0};
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ctl", {11'b0, ctl()}, {11'b0, CTL_RST});
    chk("rst_rdat", wb.wb_data_o, 32'h0);
    chk("rst_addr", {8'b0, mc_addr_o}, 32'h0);
    chk("poc", poc_o, 32'h2);
    @(negedge clk_i) rst_i = 1'b1;
    for (int i = 0; i < 17; i++) run(tv[i], $sformatf("v%0d", i));
    @(negedge clk_i) susp_req_i = 1'b1;
    @(posedge clk_i); #1;
    chk("susp_on", {30'b0, suspended_o, mc_zz_o}, 32'h3);
    susp_req_i = 1'b0;
    rv = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hCAFEF00D, 1'b1, 1, 32'h0, 1'b0, 1'b1, 8'hFF, 24'h0, 0};
    run(rv, "susp_mem");
    rv = '{1'b0, 32'h6000_0000, 32'h0, 4'hF, 32'h0, 1'b0, 1, 32'h1, 1'b1, 1'b0, 8'hFF, 24'h0, 0};
    run(rv, "susp_csr");
    chk("susp_hold", {30'b0, suspended_o, mc_zz_o}, 32'h3);
    @(negedge clk_i) resume_req_i = 1'b1;
    @(posedge clk_i); #1;
    chk("resume", {30'b0, suspended_o, mc_zz_o}, 32'h0);
    resume_req_i = 1'b0;
    @(negedge clk_i);
    wb.wb_we_i = 1'b0; wb.wb_addr_i = 32'h0000_0010; wb.wb_sel_i = 4'hF; mdl = 32'hCAFEF00D;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i); #1;
    chk("pre_rst_oe", {31'b0, mc_oe_o_}, 32'h0);
    #1 rst_i = 1'b0;
    #1;
    chk("mid_rst_ctl", {11'b0, ctl()}, {11'b0, CTL_RST});
    chk("mid_rst_addr", {8'b0, mc_addr_o}, 32'h0);
    chk("mid_rst_wdat", mc_data_o, 32'h0);
    chk("mid_rst_rdat", wb.wb_data_o, 32'h0);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;
    begin
      logic seen = 1'b0;
      repeat (4) begin
        @(posedge clk_i); #1;
        seen |= wb.wb_ack_o | wb.wb_err_o;
      end
      chk("no_abort_ack", {31'b0, seen}, 32'h0);
    end
    rv = '{1'b0, 32'h6000_0010, 32'h0, 4'hF, 32'h0, 1'b0, 1, 32'h1, 1'b1, 1'b0, 8'hFF, 24'h0, 0};
    run(rv, "post_csc0");
    rv = '{1'b0, 32'h6000_001C, 32'h0, 4'hF, 32'h0, 1'b0, 1, 32'h0, 1'b1, 1'b0, 8'hFF, 24'h0, 0};
    run(rv, "post_csc3");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
